// File: rtl/pe_array_pkg.sv
// pe_array_pkg: shared arbiter state, read latency and slice helper for the PE-array read path
package pe_array_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} arb_state_e;
  localparam int GBUF_RD_LATENCY = 1;
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction
endpackage

// File: rtl/gbuf_read_arbiter_if.sv
// gbuf_read_arbiter_if: PE request/response and global-buffer read signals of the arbiter
interface gbuf_read_arbiter_if #(
  parameter int N = 3,
  parameter int GLOBAL_BUFFER_ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH = 6
);
  logic [N-1:0] req;
  logic [N*GLOBAL_BUFFER_ADDR_WIDTH-1:0] req_addr;
  logic [N*LEN_WIDTH-1:0] req_len;
  logic [N-1:0] gnt;
  logic gbuf_rd_en;
  logic [GLOBAL_BUFFER_ADDR_WIDTH-1:0] gbuf_addr;
  logic [DATA_WIDTH-1:0] gbuf_rdata;
  logic [DATA_WIDTH-1:0] pe_data;
  logic [N-1:0] pe_valid;
  logic [N-1:0] pe_done;
  logic busy;
  modport master (
    input req, req_addr, req_len, gbuf_rdata,
    output gnt, gbuf_rd_en, gbuf_addr, pe_data, pe_valid, pe_done, busy
  );
  modport slave (
    output req, req_addr, req_len, gbuf_rdata,
    input gnt, gbuf_rd_en, gbuf_addr, pe_data, pe_valid, pe_done, busy
  );
endinterface

// File: rtl/gbuf_read_arbiter_picker.sv
// rr_priority_picker: one-hot winner, searching requests upward from index ptr_i with wrap
module rr_priority_picker #(
  parameter int N = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  win_o
);
  logic [N-1:0] rot, rot_win;
  // rotate so ptr_i sits at bit 0, isolate the lowest set bit, rotate back
  assign rot = N'({req_i, req_i} >> ptr_i);
  assign rot_win = rot & -rot;
  assign win_o = N'(({rot_win, rot_win} << ptr_i) >> N);
endmodule

// File: rtl/gbuf_read_arbiter.sv
// gbuf_read_arbiter: grants the global-buffer read port to one PE per burst and steers data back.
// Define GBUF_ARB_FIXED_PRI_EN for fixed lowest-index priority instead of round-robin.
module gbuf_read_arbiter
  import pe_array_pkg::*;
#(
  parameter int N = 3,
  parameter int GLOBAL_BUFFER_ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH = 6
) (
  input logic clk,
  input logic rst,
  gbuf_read_arbiter_if.master bus
);
  localparam int AW = GLOBAL_BUFFER_ADDR_WIDTH;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int VW = GBUF_RD_LATENCY * N;
  arb_state_e state_q, state_d;
  logic [N-1:0] gnt_q, gnt_d, win;
  logic [VW-1:0] vld_q;
  logic [AW-1:0] addr_q, addr_d, base_w;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d, len_w;
  logic [PW-1:0] ptr_q;
  logic rd_en, go;
  rr_priority_picker #(.N(N), .PW(PW)) u_picker (.req_i(bus.req), .ptr_i(ptr_q), .win_o(win));
`ifdef GBUF_ARB_FIXED_PRI_EN
  assign ptr_q = '0;
`else
  logic [PW-1:0] ptr_d;
  // search for the next round starts just past the latest winner
  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < N; i++) if (go && win[i]) ptr_d = PW'((i + 1) % N);
  end
  always_ff @(posedge clk) ptr_q <= rst ? '0 : ptr_d;
`endif
  always_comb begin
    base_w = '0;
    len_w = '0;
    for (int i = 0; i < N; i++) begin
      base_w |= win[i] ? bus.req_addr[slice_lo(i, AW) +: AW] : '0;
      len_w |= win[i] ? bus.req_len[slice_lo(i, LEN_WIDTH) +: LEN_WIDTH] : '0;
    end
  end
  always_ff @(posedge clk) begin
    state_q <= rst ? IDLE : state_d;
    gnt_q <= rst ? '0 : gnt_d;
    addr_q <= rst ? '0 : addr_d;
    cnt_q <= rst ? '0 : cnt_d;
    vld_q <= rst ? '0 : VW'({vld_q, (rd_en ? gnt_q : N'(0))});
  end
  always_comb begin
    go = state_q == IDLE && |bus.req;
    state_d = (state_q == IDLE) ? (go ? ((len_w == '0) ? DRAIN : ISSUE) : IDLE)
            : (state_q == ISSUE) ? ((cnt_q == LEN_WIDTH'(1)) ? DRAIN : ISSUE) : IDLE;
    gnt_d = go ? win : (state_q == DRAIN) ? '0 : gnt_q;
    addr_d = go ? base_w : rd_en ? addr_q + AW'(1) : addr_q;
    cnt_d = go ? len_w : rd_en ? cnt_q - LEN_WIDTH'(1) : cnt_q;
  end
  always_comb begin
    rd_en = state_q == ISSUE;
    bus.gbuf_rd_en = rd_en;
    bus.gbuf_addr = rd_en ? addr_q : '0;
    bus.gnt = gnt_q;
    bus.pe_done = (state_q == DRAIN) ? gnt_q : '0;
    bus.busy = state_q != IDLE;
    bus.pe_valid = vld_q[VW-1 -: N];
    bus.pe_data = DATA_WIDTH'(bus.gbuf_rdata);
  end
endmodule

// File: tb/tb_gbuf_read_arbiter.sv
// tb_gbuf_read_arbiter: directed bursts with a scoreboard of expected PE beats checked by a monitor
module tb_gbuf_read_arbiter;
  typedef struct {
    logic [2:0] vld;
    logic [15:0] data;
    logic [2:0] done;
    int gap;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  int vectors = 0, miscompares = 0;
  int cyc = 0, last_ev = 0, rd_cnt = 0, done_cnt = 0;
  bit mon_en = 1;
  exp_t sbq[$];
  exp_t me;
  gbuf_read_arbiter_if #(.N(3), .GLOBAL_BUFFER_ADDR_WIDTH(10), .DATA_WIDTH(16), .LEN_WIDTH(6)) bus ();
  gbuf_read_arbiter #(.N(3), .GLOBAL_BUFFER_ADDR_WIDTH(10), .DATA_WIDTH(16), .LEN_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] mem_f(input logic [9:0] a);
    return {6'b101101, a};
  endfunction
  always @(posedge clk) if (bus.gbuf_rd_en) bus.gbuf_rdata <= mem_f(bus.gbuf_addr);
  always @(negedge clk) begin
    cyc++;
    if (bus.gbuf_rd_en) rd_cnt++;
    if (bus.pe_done != 0) done_cnt++;
    if (mon_en && (bus.pe_valid != 0 || bus.pe_done != 0)) begin
      vectors++;
      if (sbq.size() == 0) begin
        miscompares++;
        $display("FAIL beat: unexpected pe_valid=%b pe_done=%b at cycle %0d", bus.pe_valid, bus.pe_done, cyc);
      end else begin
        me = sbq.pop_front();
        if (bus.pe_valid !== me.vld || bus.pe_done !== me.done || bus.gnt !== (me.vld | me.done)
            || (me.vld != 0 && bus.pe_data !== me.data) || (me.gap >= 0 && cyc - last_ev != me.gap)) begin
          miscompares++;
          $display("FAIL beat: got vld=%b done=%b gnt=%b data=%h gap=%0d, expected vld=%b done=%b gnt=%b data=%h gap=%0d",
                   bus.pe_valid, bus.pe_done, bus.gnt, bus.pe_data, cyc - last_ev,
                   me.vld, me.done, me.vld | me.done, me.data, me.gap);
        end
      end
      last_ev = cyc;
    end
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic check_quiet(input string tag);
    check({tag, "_gnt"}, 32'(bus.gnt), 0);
    check({tag, "_rd_en"}, 32'(bus.gbuf_rd_en), 0);
    check({tag, "_addr"}, 32'(bus.gbuf_addr), 0);
    check({tag, "_pe_valid"}, 32'(bus.pe_valid), 0);
    check({tag, "_pe_done"}, 32'(bus.pe_done), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
  endtask
  task automatic push_burst(input int pe, input logic [9:0] a, input int len, input int first_gap);
    exp_t e;
    if (len == 0) begin
      e.vld = 0; e.data = 0; e.done = 3'(1 << pe); e.gap = first_gap;
      sbq.push_back(e);
    end
    for (int k = 0; k < len; k++) begin
      e.vld = 3'(1 << pe);
      e.data = mem_f(a + 10'(k));
      e.done = (k == len - 1) ? 3'(1 << pe) : 3'b0;
      e.gap = (k == 0) ? first_gap : 1;
      sbq.push_back(e);
    end
  endtask
  task automatic set_req(input int pe, input logic [9:0] a, input logic [5:0] l);
    bus.req_addr[pe*10 +: 10] = a;
    bus.req_len[pe*6 +: 6] = l;
    bus.req[pe] = 1'b1;
  endtask
  task automatic wait_gnt(input int pe);
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.gnt[pe] && n < 20);
    check("gnt_seen", 32'(bus.gnt[pe]), 1);
  endtask
  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while (bus.busy && n < 200);
    check("back_to_idle", 32'(bus.busy), 0);
    check("scoreboard_empty", sbq.size(), 0);
  endtask
  task automatic single(input int pe, input logic [9:0] a, input int len, input int hold);
    rd_cnt = 0;
    push_burst(pe, a, len, -1);
    set_req(pe, a, 6'(len));
    wait_gnt(pe);
    repeat (hold) @(negedge clk);
    bus.req[pe] = 1'b0;
    wait_idle();
    check("read_count", rd_cnt, len);
  endtask
  initial begin
    int n;
    bus.req = 0; bus.req_addr = 0; bus.req_len = 0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    rst = 0;
    @(negedge clk);
    check_quiet("post_reset");
    single(1, 10'd100, 5, 0);
    single(0, 10'd1022, 4, 0);
    single(2, 10'd7, 0, 0);
    single(0, 10'd200, 10, 3);
    mon_en = 0;
    done_cnt = 0;
    set_req(1, 10'd300, 6'd10);
    wait_gnt(1);
    bus.req[1] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check_quiet("mid_burst_reset");
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check_quiet("after_abort");
    check("abort_no_done", done_cnt, 0);
    mon_en = 1;
`ifdef GBUF_ARB_FIXED_PRI_EN
    for (int r = 0; r < 6; r++) push_burst(0, 10'h010, 2, r == 0 ? -1 : 3);
`else
    for (int r = 0; r < 6; r++) push_burst(r % 3, 10'(16 * (r % 3 + 1)), 2, r == 0 ? -1 : 3);
`endif
    set_req(0, 10'h010, 6'd2);
    set_req(1, 10'h020, 6'd2);
    set_req(2, 10'h030, 6'd2);
    n = 0;
    for (int t = 0; t < 200 && n < 6; t++) begin
      @(negedge clk);
      if (bus.pe_done != 0) n++;
    end
    bus.req = 0;
    check("contended_bursts", n, 6);
    wait_idle();
    repeat (3) @(negedge clk);
    check_quiet("final");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/gbuf_read_arbiter.md
# gbuf_read_arbiter

Shares the single global-buffer read port between the N processing elements of the PE array. Each PE raises a fill request with a base address and word count. The arbiter grants one PE at a time, issues a contiguous read burst, and steers returned words into that PE's ifmap/filter buffer. It sits between the PE array and the global buffer, under the top-level convolution controller.

## Interface
- N, 3, number of PE requesters
- GLOBAL_BUFFER_ADDR_WIDTH, 10, global buffer address width
- DATA_WIDTH, 16, word width
- LEN_WIDTH, 6, burst length width (max 63 words, covers 60-entry PE buffers)

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  N  per-PE fill request, level
- req_addr  in  N*GLOBAL_BUFFER_ADDR_WIDTH  per-PE base address, slice i for PE i
- req_len  in  N*LEN_WIDTH  per-PE word count, slice i for PE i
- gnt  out  N  one-hot grant, held for whole burst
- gbuf_rd_en  out  1  global buffer read strobe
- gbuf_addr  out  GLOBAL_BUFFER_ADDR_WIDTH  read address
- gbuf_rdata  in  DATA_WIDTH  read data, valid 1 cycle after gbuf_rd_en
- pe_data  out  DATA_WIDTH  broadcast data to PEs
- pe_valid  out  N  one-hot, pe_data is valid for PE i
- pe_done  out  N  one-cycle pulse, burst for PE i complete
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - With req != 0, pick a winner and latch its base address and length (cnt = len).
  - Assert gnt[winner] and go to ISSUE.
  - With req == 0, stay in IDLE.
- ISSUE:
  - gbuf_rd_en = 1 and gbuf_addr = base + issued each cycle; cnt decrements.
  - After the last word is issued, go to DRAIN.
- DRAIN:
  - Final data beat is delivered.
  - pe_done[winner] pulses; gnt clears on the transition back to IDLE.
- Length 0: the grant is given and ISSUE is skipped. DRAIN pulses pe_done with no reads and no pe_valid.
- Address arithmetic is modulo 2^GLOBAL_BUFFER_ADDR_WIDTH. It wraps silently, with no depth check.
- pe_valid[i] = registered (gbuf_rd_en & gnt[i]). pe_data = gbuf_rdata passed through, unregistered.
- req deasserted mid-burst is ignored: the burst always completes. req and req_addr/req_len are sampled only in IDLE.
- Arbitration is round-robin. The search starts at last_winner+1 modulo N, and last_winner updates on each grant.
- The winner's own req, if still high after done, is lowest priority next round.
- Reset:
  - All outputs go to 0 and the state goes to IDLE.
  - The RR pointer goes to 0, so PE0 has highest priority first.
  - Reset mid-burst aborts the burst with no pe_done.

## Timing
- Arbitration decision in cycle c (IDLE); gnt and gbuf_rd_en first high in c+1.
- For a burst of length L:
  - gbuf_rd_en is high in c+1..c+L.
  - pe_valid is high in c+2..c+L+1.
  - The DRAIN cycle is c+L+1, with pe_done aligned to the last pe_valid.
- IDLE in c+L+2; the next grant is visible at c+L+3. Bus overhead is 2 idle cycles per burst.
- L=0: gnt is high in c+1 (DRAIN) with pe_done in the same cycle.
- Simultaneous requests: exactly one gnt bit at a time, never overlapping bursts.

## Configuration
- GBUF_ARB_FIXED_PRI_EN defined: fixed priority, lowest-index requesting PE always wins, and the RR pointer logic is removed.
- GBUF_ARB_FIXED_PRI_EN undefined (default): round-robin as above.

## Structure
- Shared package pe_array_pkg holds:
  - the arbiter state enum (IDLE/ISSUE/DRAIN);
  - GBUF_RD_LATENCY = 1;
  - the slice helper for req_addr/req_len indexing.
- One sub-module, rr_priority_picker: combinational N-bit request vector + pointer → one-hot winner.

## Test plan
- Reset: rst high for 2 cycles mid-burst → all outputs 0 and busy 0 next cycle; no pe_done emitted.
- Single request, PE1 addr=100, len=5:
  - gbuf_addr 100..104 on 5 consecutive cycles.
  - pe_valid[1] for 5 cycles, data matching memory.
  - pe_done[1] with the 5th beat.
- All three PEs request continuously, len=2 → grants in order 0,1,2,0,… with no overlap and 2-cycle gaps. With GBUF_ARB_FIXED_PRI_EN, only PE0 is granted.
- Wrap: addr=1022, len=4 → addresses 1022,1023,0,1.
- len=0 from PE2 → one-cycle gnt[2] with pe_done[2]; gbuf_rd_en stays 0.
- PE0 drops req mid-burst (len=10) → all 10 reads complete, then pe_done[0].
